// File: rtl/icache_direct.sv
// Purpose: direct-mapped instruction cache, 16 lines x 4 words, refilled one word per beat from memctrl.
// Latency: hit result 1 cycle after the request; miss result 2 cycles after the fourth refill word.
// Backpressure: rdy_in low freezes all state; requests while busy are ignored; clear drops pending results.
`timescale 1ns/1ps
module icache_direct (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        to_icache,
  input  logic [31:0] pc_to_icache,
  input  logic        clear,
  output logic        have_result,
  output logic [31:0] inst_from_icache,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_word_valid,
  input  logic [31:0] mem_word
);

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Storage: data and tags carry no reset, only the valid bits do.
  logic [31:0] r_data [16][4];
  logic [23:0] r_tag  [16];
  logic [15:0] r_valid;

  logic [31:2] r_pc;
  logic [1:0]  r_cnt;
  logic        r_flushed;
  logic        r_have_result;
  logic [31:0] r_inst;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;

  logic [3:0]  w_idx_req;
  logic [1:0]  w_off_req;
  logic [23:0] w_tag_req;
  logic        w_hit;
  logic        w_accept;
  logic        w_fill_last;
  logic        w_miss_start;
  logic        w_set_result;
  logic [31:0] w_result_dat;
  logic [3:0]  w_idx_l;
  logic [1:0]  w_off_l;
  logic        w_unused_ok;

  // Byte offset bits of the fetch address carry no information for word fetches.
  assign w_unused_ok = &{1'b1, pc_to_icache[1:0]};

  assign w_idx_req   = pc_to_icache[7:4];
  assign w_off_req   = pc_to_icache[3:2];
  assign w_tag_req   = pc_to_icache[31:8];
  assign w_hit       = r_valid[w_idx_req] && (r_tag[w_idx_req] == w_tag_req);
  // A flush in the same cycle as the strobe discards the request outright.
  assign w_accept    = to_icache && !clear;
  assign w_idx_l     = r_pc[7:4];
  assign w_off_l     = r_pc[3:2];
  assign w_fill_last = (r_state == S_REFILL) && mem_word_valid && (r_cnt == 2'd3);

  assign busy             = (r_state != S_IDLE);
  assign mem_req          = r_mem_req;
  assign mem_addr         = r_mem_addr;
  assign inst_from_icache = r_inst;
  // A flush arriving in the pulse cycle still kills an already scheduled hit result.
  assign have_result      = r_have_result && !clear;

  // Next-state and result selection for the IDLE/REFILL/RESP controller.
  always_comb begin
    w_state_nxt  = r_state;
    w_set_result = 1'b0;
    w_result_dat = r_inst;
    w_miss_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_hit) begin
            w_set_result = 1'b1;
            w_result_dat = r_data[w_idx_req][w_off_req];
          end else begin
            w_miss_start = 1'b1;
            w_state_nxt  = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        if (w_fill_last) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        if (!clear && !r_flushed) begin
          w_set_result = 1'b1;
          w_result_dat = r_data[w_idx_l][w_off_l];
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state, refill bookkeeping, valid bits and output registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state       <= S_IDLE;
      r_valid       <= '0;
      r_pc          <= '0;
      r_cnt         <= 2'd0;
      r_flushed     <= 1'b0;
      r_have_result <= 1'b0;
      r_inst        <= '0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
    end else if (rdy_in) begin
      r_state       <= w_state_nxt;
      r_have_result <= w_set_result;
      if (w_set_result) r_inst <= w_result_dat;
      if ((r_state == S_IDLE) && w_accept) r_pc <= pc_to_icache[31:2];
      if (w_miss_start) begin
        // The victim line is invalidated up front so an abandoned refill never looks valid.
        r_valid[w_idx_req] <= 1'b0;
        r_mem_req          <= 1'b1;
        r_mem_addr         <= {pc_to_icache[31:4], 4'b0000};
        r_cnt              <= 2'd0;
        r_flushed          <= 1'b0;
      end
      if (r_state == S_REFILL) begin
        if (mem_word_valid) r_cnt <= r_cnt + 2'd1;
        if (clear) r_flushed <= 1'b1;
        if (w_fill_last) begin
          r_mem_req        <= 1'b0;
          r_valid[w_idx_l] <= 1'b1;
        end
      end
    end
  end

  // Refill writes into the data and tag arrays; words arrive in order 0..3.
  always_ff @(posedge clk_in) begin
    if (rdy_in && (r_state == S_REFILL) && mem_word_valid) begin
      r_data[w_idx_l][r_cnt] <= mem_word;
      if (r_cnt == 2'd3) r_tag[w_idx_l] <= r_pc[31:8];
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Purpose: scoreboard bench for icache_direct against a line-level cache model and a hashed memory image.
// Latency: expects hit results 1 cycle after the strobe, miss results 2 cycles after the fourth word.
// Backpressure: exercises rdy_in pauses, flushes in every state, and asynchronous reset mid-refill.
`timescale 1ns/1ps
module tb_icache_direct;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        to_icache = 1'b0;
  logic [31:0] pc_to_icache = '0;
  logic        clear = 1'b0;
  logic        mem_word_valid = 1'b0;
  logic [31:0] mem_word = '0;
  logic        have_result;
  logic [31:0] inst_from_icache;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;

  icache_direct dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .to_icache(to_icache),
    .pc_to_icache(pc_to_icache), .clear(clear), .have_result(have_result),
    .inst_from_icache(inst_from_icache), .busy(busy), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_word_valid(mem_word_valid), .mem_word(mem_word)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] dat;
    int          due;
  } exp_t;
  exp_t sb[$];

  // Reference model: which line base each index holds, plus the memory image.
  logic [31:0] m_line [16];
  bit          m_val  [16];
  logic [31:0] mem_ov [logic [31:0]];

  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem_ov.exists(w)) return mem_ov[w];
    return (w * 32'h9E3779B1) ^ 32'h5A5A0000 ^ (w >> 3);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_val[pc[7:4]] && (m_line[pc[7:4]] == {pc[31:4], 4'h0});
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation, data and cycle.
  always @(negedge clk_in) begin
    exp_t e;
    if (rst_in === 1'b1 && have_result === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got inst %h at cycle %0d, expected no result", inst_from_icache, cyc);
      end else begin
        e = sb.pop_front();
        chk("result_inst", inst_from_icache, e.dat);
        chk("result_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // One complete fetch; clr_at 0..3 flushes with that refill word, 4 flushes in the response cycle.
  task automatic fetch(input logic [31:0] pc, input int clr_at, input bit pause, input int max_gap);
    logic [31:0] base;
    int          idx;
    int          last;
    int          gap;
    bit          flushed;
    base    = {pc[31:4], 4'h0};
    idx     = int'(pc[7:4]);
    flushed = 1'b0;
    last    = 0;
    to_icache    = 1'b1;
    pc_to_icache = pc;
    if (model_hit(pc)) begin
      sb.push_back('{memf(pc), cyc + 1});
      tick();
      to_icache = 1'b0;
      chk("hit_mem_req", {31'b0, mem_req}, 32'd0);
      chk("hit_busy", {31'b0, busy}, 32'd0);
    end else begin
      tick();
      to_icache    = 1'b0;
      pc_to_icache = $urandom;
      chk("miss_mem_req", {31'b0, mem_req}, 32'd1);
      chk("miss_mem_addr", mem_addr, base);
      chk("miss_busy", {31'b0, busy}, 32'd1);
      m_val[idx] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (gap) tick();
        if (pause && i == 1) begin
          rdy_in = 1'b0;
          repeat (3) tick();
          chk("pause_mem_req", {31'b0, mem_req}, 32'd1);
          rdy_in = 1'b1;
        end
        mem_word_valid = 1'b1;
        mem_word       = memf(base + 32'(4 * i));
        if (clr_at == i) begin
          clear   = 1'b1;
          flushed = 1'b1;
        end
        last = cyc;
        tick();
        mem_word_valid = 1'b0;
        mem_word       = $urandom;
        clear          = 1'b0;
      end
      m_line[idx] = base;
      m_val[idx]  = 1'b1;
      if (clr_at == 4) begin
        clear   = 1'b1;
        flushed = 1'b1;
        tick();
        clear = 1'b0;
      end
      if (!flushed) sb.push_back('{memf(pc), last + 2});
      for (int k = 0; k < 8 && busy; k++) tick();
      chk("return_idle", {31'b0, busy}, 32'd0);
      chk("refill_mem_req_low", {31'b0, mem_req}, 32'd0);
    end
  endtask

  // Strobe and flush in the same cycle: nothing may happen.
  task automatic discard(input logic [31:0] pc);
    tick();
    to_icache    = 1'b1;
    pc_to_icache = pc;
    clear        = 1'b1;
    tick();
    to_icache = 1'b0;
    clear     = 1'b0;
    chk("discard_busy", {31'b0, busy}, 32'd0);
    chk("discard_mem_req", {31'b0, mem_req}, 32'd0);
    tick();
  endtask

  // A hit whose result pulse coincides with a flush must not be reported.
  task automatic hit_then_clear(input logic [31:0] pc);
    tick();
    chk("hitclr_model_hit", {31'b0, model_hit(pc)}, 32'd1);
    to_icache    = 1'b1;
    pc_to_icache = pc;
    tick();
    to_icache = 1'b0;
    clear     = 1'b1;
    chk("hitclr_busy", {31'b0, busy}, 32'd0);
    tick();
    clear = 1'b0;
  endtask

  // Reset dropped between clock edges in the middle of a refill.
  task automatic arst_mid_refill(input logic [31:0] pc);
    tick();
    to_icache    = 1'b1;
    pc_to_icache = pc;
    tick();
    to_icache = 1'b0;
    chk("arst_pre_mem_req", {31'b0, mem_req}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      mem_word_valid = 1'b1;
      mem_word       = memf({pc[31:4], 4'h0} + 32'(4 * i));
      tick();
      mem_word_valid = 1'b0;
    end
    #2;
    rst_in = 1'b0;
    #1;
    chk("arst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_have_result", {31'b0, have_result}, 32'd0);
    for (int i = 0; i < 16; i++) m_val[i] = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
    fetch(pc, -1, 1'b0, 0);
  endtask

  task automatic junk_word();
    mem_word_valid = 1'b1;
    mem_word       = $urandom;
    tick();
    mem_word_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;
    int          clr_at;
    for (int i = 0; i < 16; i++) m_val[i] = 1'b0;
    mem_ov[32'h100] = 32'h000000A0;
    mem_ov[32'h104] = 32'h000000A1;
    mem_ov[32'h108] = 32'h000000A2;
    mem_ov[32'h10C] = 32'h000000A3;

    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_have_result", {31'b0, have_result}, 32'd0);
    chk("rst_inst", inst_from_icache, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst_in = 1'b1;
    tick();

    fetch(32'h0000_0104, -1, 1'b0, 0);   // cold miss, expects 0xA1
    fetch(32'h0000_010C, -1, 1'b0, 0);   // hit, expects 0xA3
    fetch(32'h0000_0204, -1, 1'b0, 0);   // conflict at index 0
    fetch(32'h0000_0104, -1, 1'b0, 0);   // evicted, misses again
    fetch(32'h0000_0308,  1, 1'b0, 0);   // flush with second word
    fetch(32'h0000_0300, -1, 1'b0, 0);   // installed line hits
    fetch(32'h0000_1040, -1, 1'b1, 0);   // three-cycle pause
    fetch(32'h0000_1048, -1, 1'b0, 0);
    fetch(32'h0000_2050,  4, 1'b0, 0);   // flush in response cycle
    fetch(32'h0000_2054, -1, 1'b0, 0);
    hit_then_clear(32'h0000_1044);
    discard(32'h0000_0300);
    discard(32'h0000_5000);
    fetch(32'h0000_5000, -1, 1'b0, 0);   // discarded miss was never started
    arst_mid_refill(32'h0000_3070);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) junk_word();
      pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4) |
           ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      clr_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      fetch(pc, clr_at, ($urandom_range(0, 7) == 0), 2);
    end

    repeat (5) tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
ICACHE_DIRECT -- requirements
Module: icache_direct

Interface
REQ-001 The block SHALL have parameters: none; geometry is fixed at 16 lines x 4 words (256 B), direct-mapped, index pc[7:4], word offset pc[3:2], tag pc[31:8].
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports in this order:
  clk_in  in  1  clock, all state on rising edge
  rst_in  in  1  reset, asynchronous, active-low
  rdy_in  in  1  pause when low; all state frozen
  to_icache  in  1  fetch request strobe, one-cycle pulse from ifetch
  pc_to_icache  in  32  fetch address, valid with to_icache, bits [1:0] ignored
  clear  in  1  pipeline flush from rob (mispredict)
  have_result  out  1  one-cycle pulse, inst_from_icache valid
  inst_from_icache  out  32  fetched instruction word
  busy  out  1  high whenever state is not IDLE
  mem_req  out  1  line refill request, held until fourth word received
  mem_addr  out  32  refill line base, {pc[31:4],4'b0}
  mem_word_valid  in  1  one refill word valid this cycle
  mem_word  in  32  refill word, line words delivered in order 0..3

Function
REQ-003 The block SHALL implement states IDLE, REFILL, RESP.
REQ-004 In IDLE with to_icache=1, it SHALL look up index/tag combinationally against pc_to_icache and latch pc.
REQ-005 On hit, it SHALL drive have_result=1 and inst_from_icache=data[index][offset] on the next cycle (latency 1), remaining in IDLE.
REQ-006 On miss, it SHALL enter REFILL next cycle with mem_req=1, mem_addr=line base of latched pc, and a 2-bit word counter at 0.
REQ-007 In REFILL, each mem_word_valid=1 cycle SHALL write mem_word into data[index][counter] and increment counter.
REQ-008 On the fourth word, it SHALL set tag[index] and valid[index], drop mem_req on the next cycle, and enter RESP.
REQ-009 In RESP, it SHALL pulse have_result with data[index][latched offset] and return to IDLE; miss latency = 4 words received + 2 cycles.
REQ-010 have_result SHALL be high for exactly one cycle per accepted, unflushed request; inst_from_icache SHALL hold its value until the next result.
REQ-011 to_icache while busy=1 SHALL be ignored (no queueing); ifetch guarantees no such strobe.
REQ-012 clear in IDLE SHALL suppress a same-cycle hit result and a pending hit pulse scheduled for the next cycle.
REQ-013 clear in REFILL SHALL NOT abort the refill; the line SHALL be installed, and the result SHALL be dropped (no have_result) with return to IDLE.
REQ-014 clear in RESP SHALL suppress have_result; the state SHALL return to IDLE.
REQ-015 clear and to_icache in the same IDLE cycle SHALL result in the request being discarded.
REQ-016 A line SHALL replace the old line at the same index unconditionally; there is no write path and no dirty state.
REQ-017 With rdy_in=0, no state, counter, array, or output register SHALL change; memctrl never asserts mem_word_valid while rdy_in=0.
REQ-018 mem_word_valid outside REFILL SHALL be ignored.

Reset
REQ-019 Reset SHALL be effective immediately when rst_in=0, independent of clk_in.
REQ-020 On reset, state=IDLE, all valid bits=0, counter=0, have_result=0, inst_from_icache=0, mem_req=0, mem_addr=0, busy=0; data and tag arrays are not reset.
REQ-021 Reset asserted mid-REFILL SHALL abandon the refill, leaving that line invalid.

Verification
REQ-022 Cold miss: after reset, pc=0x00000104 -> mem_req=1, mem_addr=0x00000100; words 0xA0,0xA1,0xA2,0xA3 -> have_result with 0xA1, 2 cycles after the fourth word.
REQ-023 Hit: then pc=0x0000010C -> have_result=1, inst=0xA3 exactly 1 cycle later, mem_req stays 0.
REQ-024 Conflict: pc=0x00000204 (same index 0, new tag) -> refill from 0x00000200; a re-fetch of 0x00000104 then misses again.
REQ-025 Flush mid-refill: clear during word 2 of a refill -> words 3-4 still accepted, no have_result, a following fetch of the same line hits in 1 cycle.
REQ-026 Pause: rdy_in=0 for 3 cycles between words 1 and 2 -> counter and mem_req held, result identical to the unpaused run, latency extended by 3 cycles.
REQ-027 Async reset: rst_in low mid-REFILL, no clock edge -> mem_req=0 and busy=0 immediately; a re-fetch of the same pc misses.
